serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one sum bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output Ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic [WIDTH-1:0] Sum,
   output logic             C_out,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_bit;
   logic             w_carry;
   logic             w_last;
   logic [WIDTH-1:0] w_s_next;

   assign w_bit    = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
   assign w_last   = (r_cnt == LAST_BIT);
   assign w_s_next = {w_bit, r_s[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_SHIFT;
         S_SHIFT: if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_SHIFT: busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // The fill bit entering r_a's MSB cannot reach the LSB within WIDTH shifts,
   // so recycling the discarded sum LSB there is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_s     <= '0;
                  r_carry <= C_in;
                  r_cnt   <= '0;
               end
            end
            S_SHIFT: begin
               r_a     <= {r_s[0], r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_s     <= w_s_next;
               r_carry <= w_carry;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum  <= w_s_next;
                  r_cout <= w_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign Sum   = r_sum;
   assign C_out = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the last shift r_carry is the carry into the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_SHIFT && w_last) begin
         r_ovf <= r_carry ^ w_carry;
      end
   end

   assign Ovf = r_ovf;
`endif

endmodule
